// File: rtl/intersection_phase_scheduler.sv
// Round-robin traffic phase scheduler: latches per-phase requests and runs a
// timed green -> yellow -> all-red sequence for one phase at a time.
// Optional emergency preemption is enabled by defining EMERG_PREEMPT_EN.
module intersection_phase_scheduler #(
   parameter int N_PHASE      = 4,
   parameter int TICK_DIV     = 4,
   parameter int GREEN_TICKS  = 10,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_PHASE-1:0]     req,
`ifdef EMERG_PREEMPT_EN
   input  logic                   emerg,
   input  logic [$clog2(N_PHASE)-1:0] emerg_phase,
`endif
   output logic [2*N_PHASE-1:0]   light,
   output logic [N_PHASE-1:0]     grant,
   output logic [N_PHASE-1:0]     pending,
   output logic                   busy
);

   localparam int PH_W  = $clog2(N_PHASE);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int T_GY  = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int T_MAX = (T_GY > ALLRED_TICKS) ? T_GY : ALLRED_TICKS;
   localparam int TMR_W = $clog2(T_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;
   logic [TMR_W-1:0]    timer, timer_nxt;
   logic [N_PHASE-1:0]  grant_nxt;
   logic [PH_W-1:0]     last, last_nxt;
   logic [N_PHASE-1:0]  issue;
   logic [N_PHASE-1:0]  green_mask;
   logic [N_PHASE-1:0]  eff_pend;
   logic [PH_W-1:0]     rr_sel;
   logic                rr_hit;
   logic                emerg_on;
   logic [PH_W-1:0]     emerg_ph;
   logic [N_PHASE-1:0]  emerg_vec;
   logic                preempt;
   logic                hold;

   function automatic logic [N_PHASE-1:0] onehot(input logic [PH_W-1:0] idx);
      return N_PHASE'(1) << idx;
   endfunction

`ifdef EMERG_PREEMPT_EN
   assign emerg_on = emerg & (32'(emerg_phase) < 32'(N_PHASE));
   assign emerg_ph = emerg_phase;
`else
   assign emerg_on = 1'b0;
   assign emerg_ph = '0;
`endif

   assign emerg_vec  = emerg_on ? onehot(emerg_ph) : '0;
   assign preempt    = emerg_on && (state == S_GREEN) && ((grant & emerg_vec) == '0);
   assign hold       = emerg_on && (state == S_GREEN) && ((grant & emerg_vec) != '0);
   assign green_mask = ((state == S_GREEN) || (state == S_YELLOW)) ? grant : '0;
   assign eff_pend   = pending | emerg_vec;
   assign tick       = (tick_cnt == CNT_W'(TICK_DIV - 1));

   // Round-robin pick: nearest set bit after the last-served phase wins.
   always_comb begin
      rr_sel = '0;
      rr_hit = 1'b0;
      for (int k = N_PHASE; k >= 1; k--) begin
         if (eff_pend[(int'(last) + k) % N_PHASE]) begin
            rr_sel = PH_W'((int'(last) + k) % N_PHASE);
            rr_hit = 1'b1;
         end
      end
   end

   // State register and all sequencing state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         timer    <= '0;
         grant    <= '0;
         last     <= PH_W'(N_PHASE - 1);
         pending  <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
         timer    <= timer_nxt;
         grant    <= grant_nxt;
         last     <= last_nxt;
         pending  <= (pending | req) & ~green_mask & ~issue;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      grant_nxt = grant;
      last_nxt  = last;
      issue     = '0;
      case (state)
         S_IDLE: begin
            if (rr_hit) begin
               state_nxt = S_GREEN;
               timer_nxt = '0;
               grant_nxt = onehot(rr_sel);
               last_nxt  = rr_sel;
               issue     = onehot(rr_sel);
            end
         end
         S_GREEN: begin
            if (preempt) begin
               state_nxt = S_YELLOW;
               timer_nxt = '0;
            end else if (hold) begin
               timer_nxt = '0;
            end else if (tick) begin
               if (timer == TMR_W'(GREEN_TICKS - 1)) begin
                  state_nxt = S_YELLOW;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
         end
         S_YELLOW: begin
            if (tick) begin
               if (timer == TMR_W'(YELLOW_TICKS - 1)) begin
                  state_nxt = S_ALLRED;
                  timer_nxt = '0;
                  grant_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
         end
         S_ALLRED: begin
            if (tick) begin
               if (timer == TMR_W'(ALLRED_TICKS - 1)) begin
                  timer_nxt = '0;
                  if (emerg_on) begin
                     state_nxt = S_GREEN;
                     grant_nxt = emerg_vec;
                     last_nxt  = emerg_ph;
                     issue     = emerg_vec;
                  end else if (rr_hit) begin
                     state_nxt = S_GREEN;
                     grant_nxt = onehot(rr_sel);
                     last_nxt  = rr_sel;
                     issue     = onehot(rr_sel);
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            grant_nxt = '0;
         end
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      light = '0;
      busy  = (state != S_IDLE);
      for (int i = 0; i < N_PHASE; i++) begin
         if (grant[i]) begin
            if (state == S_GREEN)
               light[2*i +: 2] = 2'b10;
            else if (state == S_YELLOW)
               light[2*i +: 2] = 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler at default parameters.
// The emergency section runs only when EMERG_PREEMPT_EN is defined.
module tb_intersection_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] light;
   logic [3:0] grant;
   logic [3:0] pending;
   logic       busy;
`ifdef EMERG_PREEMPT_EN
   logic       emerg;
   logic [1:0] emerg_phase;
`endif

   int errs   = 0;
   int checks = 0;

   intersection_phase_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
`ifdef EMERG_PREEMPT_EN
      .emerg       (emerg),
      .emerg_phase (emerg_phase),
`endif
      .light       (light),
      .grant       (grant),
      .pending     (pending),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Follows one complete grant of phase ph; optionally re-pulses req[ph] mid-green.
   task automatic serve(input int ph, input int pulse_at);
      int n;
      logic [7:0] gpat, ypat;
      logic [3:0] oh;
      oh   = 4'(1 << ph);
      gpat = 8'(2 << (2 * ph));
      ypat = 8'(1 << (2 * ph));
      n = 0;
      while (grant != oh && n < 200) begin n++; step(); end
      chk($sformatf("grant_p%0d", ph), grant, oh);
      chk($sformatf("green_p%0d", ph), light, gpat);
      n = 0;
      while (light == gpat && n < 200) begin
         req = (n == pulse_at) ? oh : 4'b0;
         n++;
         step();
         if (pulse_at >= 0 && n == pulse_at + 1) chk("pend_in_green", pending, 0);
      end
      req = 4'b0;
      chk($sformatf("green_len_p%0d", ph), (n >= 37 && n <= 40), 1);
      chk($sformatf("yellow_p%0d", ph), light, ypat);
      n = 0;
      while (light == ypat && n < 200) begin n++; step(); end
      chk($sformatf("yellow_len_p%0d", ph), n, 12);
      chk($sformatf("allred_p%0d", ph), {light, grant, 3'b0, busy}, 16'h0001);
      n = 0;
      while (busy && grant == 4'b0 && n < 200) begin n++; step(); end
      chk($sformatf("allred_len_p%0d", ph), n, 4);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  n;
      logic bad;
      rst = 1'b0;
      req = 4'b0;
`ifdef EMERG_PREEMPT_EN
      emerg = 1'b0;
      emerg_phase = 2'd0;
`endif
      repeat (3) step();
      chk("rst_light", light, 0);
      chk("rst_grant", grant, 0);
      chk("rst_pending", pending, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;

      bad = 1'b0;
      repeat (100) begin
         step();
         if (light != 0 || grant != 0 || busy != 0) bad = 1'b1;
      end
      chk("idle_quiet", bad, 0);

      // single pulse on phase 1
      req = 4'b0010; step(); req = 4'b0;
      chk("pulse_pending", pending, 4'b0010);
      chk("pulse_grant_wait", grant, 0);
      step();
      chk("pulse_light", light, 8'b0000_1000);
      serve(1, -1);
      chk("pulse_idle_busy", busy, 0);
      chk("pulse_idle_pend", pending, 0);

      // three requesters from a fresh round-robin position after phase 1
      req = 4'b1011; step(); req = 4'b0;
      serve(3, -1);
      serve(0, -1);
      serve(1, -1);
      chk("rr3_idle", busy, 0);

      // request from the phase holding green is discarded
      req = 4'b0100; step(); req = 4'b0;
      serve(2, 10);
      chk("no_regrant_busy", busy, 0);
      chk("no_regrant_pend", pending, 0);

      // wrap-around: after phase 3, phase 0 comes before phase 3
      req = 4'b1000; step(); req = 4'b0;
      serve(3, -1);
      req = 4'b1001; step(); req = 4'b0;
      serve(0, -1);
      serve(3, -1);
      chk("wrap_idle", busy, 0);

      // asynchronous reset in the middle of green
      req = 4'b0001; step(); req = 4'b0;
      step();
      repeat (5) step();
      chk("pre_rst_light", light, 8'b0000_0010);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_light", light, 0);
      chk("async_rst_grant", grant, 0);
      chk("async_rst_busy", busy, 0);
      step();
      rst = 1'b1;
      step();
      chk("post_rst_idle", {light, grant, 3'b0, busy}, 0);

`ifdef EMERG_PREEMPT_EN
      req = 4'b0001; step(); req = 4'b0;
      step();
      repeat (8) step();
      chk("emg_pre_green", light, 8'b0000_0010);
      emerg = 1'b1;
      emerg_phase = 2'd2;
      step();
      chk("emg_yellow", light, 8'b0000_0001);
      n = 0;
      while (grant != 4'b0100 && n < 200) begin n++; step(); end
      chk("emg_grant", grant, 4'b0100);
      chk("emg_green", light, 8'b0010_0000);
      repeat (60) step();
      chk("emg_hold", light, 8'b0010_0000);
      emerg = 1'b0;
      n = 0;
      while (light == 8'b0010_0000 && n < 200) begin n++; step(); end
      chk("emg_release_len", (n >= 37 && n <= 40), 1);
      chk("emg_after_yellow", light, 8'b0001_0000);
      n = 0;
      while (busy && n < 200) begin n++; step(); end
      chk("emg_idle", busy, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
